// File: rtl/wb_register_file.sv
`default_nettype none
// ============================================================================
// Module   : wb_register_file
// Brief    : MIPS-style 32-entry register file with writeback mux, saturating
//            retire counter and optional same-cycle write bypass
//            (WB_WRITE_BYPASS_EN).
// Revision : 1.0 - initial release
// ============================================================================
module wb_register_file #(
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [DATA_WIDTH-1:0] SP_RESET_VALUE = 32'h7FFF_EFFC
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_CtrlRegWrite,
    input  logic                  in_CtrlALUOrMem,
    input  logic                  in_CtrlALUMemOrPC,
    input  logic [4:0]            in_WriteRegister,
    input  logic [DATA_WIDTH-1:0] in_ALUResult,
    input  logic [DATA_WIDTH-1:0] in_MemoryData,
    input  logic [DATA_WIDTH-1:0] in_PC_4,
    input  logic [4:0]            in_ReadRegister1,
    input  logic [4:0]            in_ReadRegister2,
    output logic [DATA_WIDTH-1:0] out_ReadData1,
    output logic [DATA_WIDTH-1:0] out_ReadData2,
    output logic [DATA_WIDTH-1:0] out_WriteBackData,
    output logic [31:0]           out_RetireCount
);

    localparam logic [4:0] SP_INDEX = 5'd29;

    logic [DATA_WIDTH-1:0] regs_q [1:31];
    logic [31:0]           retire_cnt_q;
    logic [31:0]           retire_cnt_d;
    logic                  commit;

    always_comb begin
        out_WriteBackData = in_ALUResult;
        if (in_CtrlALUMemOrPC) begin
            out_WriteBackData = in_PC_4;
        end else if (in_CtrlALUOrMem) begin
            out_WriteBackData = in_MemoryData;
        end
    end

    // Register 0 has no storage; reset gating is handled by the async branch.
    assign commit = in_CtrlRegWrite && (in_WriteRegister != 5'd0);

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (commit && (retire_cnt_q != 32'hFFFF_FFFF)) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= (i == int'(SP_INDEX)) ? SP_RESET_VALUE : '0;
            end
            retire_cnt_q <= 32'd0;
        end else begin
            if (commit) begin
                regs_q[in_WriteRegister] <= out_WriteBackData;
            end
            retire_cnt_q <= retire_cnt_d;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] stored(input logic [4:0] idx);
        if (idx == 5'd0) begin
            return '0;
        end
        return regs_q[idx];
    endfunction

`ifdef WB_WRITE_BYPASS_EN
    logic bypass_en;
    assign bypass_en = commit && !reset;

    always_comb begin
        out_ReadData1 = stored(in_ReadRegister1);
        out_ReadData2 = stored(in_ReadRegister2);
        if (bypass_en && (in_ReadRegister1 == in_WriteRegister)) begin
            out_ReadData1 = out_WriteBackData;
        end
        if (bypass_en && (in_ReadRegister2 == in_WriteRegister)) begin
            out_ReadData2 = out_WriteBackData;
        end
    end
`else
    always_comb begin
        out_ReadData1 = stored(in_ReadRegister1);
        out_ReadData2 = stored(in_ReadRegister2);
    end
`endif

    assign out_RetireCount = retire_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_register_file
// Brief    : Self-checking bench for wb_register_file against an array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_register_file;

    localparam logic [31:0] SP_RESET = 32'h7FFF_EFFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        we, aom, amop;
    logic [4:0]  wa, r1, r2;
    logic [31:0] alu, mem, pc4;
    logic [31:0] rd1, rd2, wbd, cnt;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] model_regs [32];
    logic [31:0] model_cnt;

    always #5 clk = ~clk;

    wb_register_file #(
        .DATA_WIDTH     (32),
        .SP_RESET_VALUE (SP_RESET)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .in_CtrlRegWrite   (we),
        .in_CtrlALUOrMem   (aom),
        .in_CtrlALUMemOrPC (amop),
        .in_WriteRegister  (wa),
        .in_ALUResult      (alu),
        .in_MemoryData     (mem),
        .in_PC_4           (pc4),
        .in_ReadRegister1  (r1),
        .in_ReadRegister2  (r2),
        .out_ReadData1     (rd1),
        .out_ReadData2     (rd2),
        .out_WriteBackData (wbd),
        .out_RetireCount   (cnt)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        model_regs[29] = SP_RESET;
        model_cnt = 32'd0;
    endtask

    function automatic logic [31:0] exp_wb();
        if (amop) return pc4;
        if (aom)  return mem;
        return alu;
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
`ifdef WB_WRITE_BYPASS_EN
        if (!reset && we && wa != 5'd0 && a == wa) return exp_wb();
`endif
        return model_regs[a];
    endfunction

    // Entered just after a negedge with inputs already driven; leaves at the next negedge.
    task automatic cycle(input string tag);
        #1;
        check({tag, ".wb"},  wbd, exp_wb());
        check({tag, ".rd1"}, rd1, exp_read(r1));
        check({tag, ".rd2"}, rd2, exp_read(r2));
        check({tag, ".cnt"}, cnt, model_cnt);
        @(posedge clk);
        if (!reset && we && wa != 5'd0) begin
            model_regs[wa] = exp_wb();
            if (model_cnt != 32'hFFFF_FFFF) model_cnt = model_cnt + 32'd1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        we = 1'b0; aom = 1'b0; amop = 1'b0; wa = 5'd0;
        alu = 32'd0; mem = 32'd0; pc4 = 32'd0;
    endtask

    task automatic randomize_inputs();
        we   = ($urandom_range(0, 3) != 0);
        aom  = $urandom_range(0, 1) == 1;
        amop = ($urandom_range(0, 3) == 0);
        wa   = 5'($urandom_range(0, 31));
        alu  = $urandom;
        mem  = $urandom;
        pc4  = $urandom;
        r1   = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
        r2   = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
    endtask

    initial begin
        idle();
        r1 = 5'd0; r2 = 5'd0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset image of every index on both ports
        for (int i = 0; i < 32; i++) begin
            r1 = 5'(i);
            r2 = 5'(31 - i);
            cycle("rst_img");
        end

        // ALU writeback to $8, read back next cycle
        we = 1'b1; wa = 5'd8; alu = 32'hDEAD_BEEF; r1 = 5'd8; r2 = 5'd0;
        cycle("alu_wr");
        idle();
        cycle("alu_rd");
        check("alu_val", rd1, 32'hDEAD_BEEF);
        check("alu_cnt", cnt, 32'd1);

        // Write to $0 is discarded and not counted
        we = 1'b1; wa = 5'd0; alu = 32'h0000_1234; r1 = 5'd0; r2 = 5'd0;
        cycle("r0_wr");
        idle();
        cycle("r0_rd");
        check("r0_val", rd1, 32'd0);
        check("r0_cnt", cnt, 32'd1);

        // PC+4 link overrides memory select; same-cycle read of $31
        we = 1'b1; aom = 1'b1; amop = 1'b1; wa = 5'd31;
        pc4 = 32'h0040_0024; mem = 32'h0000_0005; r1 = 5'd31; r2 = 5'd31;
        #1;
`ifdef WB_WRITE_BYPASS_EN
        check("link_same", rd1, 32'h0040_0024);
`else
        check("link_same", rd1, 32'd0);
`endif
        check("link_ports", rd2, rd1);
        cycle("link_wr");
        idle();
        cycle("link_rd");
        check("link_val", rd1, 32'h0040_0024);

        // Randomized traffic against the model
        for (int k = 0; k < 300; k++) begin
            randomize_inputs();
            cycle("rand");
        end

        // Saturation of the retire counter
        idle();
        force dut.retire_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.retire_cnt_q;
        model_cnt = 32'hFFFF_FFFE;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            randomize_inputs();
            we = 1'b1;
            wa = 5'(k + 1);
            cycle("sat");
        end
        idle();
        cycle("sat_hold");
        check("sat_val", cnt, 32'hFFFF_FFFF);

        // Asynchronous reset mid-cycle with a pending write to $5
        we = 1'b1; wa = 5'd5; alu = 32'hCAFE_F00D; r1 = 5'd5; r2 = 5'd29;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("arst_r5",  rd1, 32'd0);
        check("arst_sp",  rd2, SP_RESET);
        check("arst_cnt", cnt, 32'd0);
        @(negedge clk);
        cycle("arst_hold");
        reset = 1'b0;
        cycle("arst_first");
        idle();
        cycle("arst_after");
        check("arst_commit", rd1, 32'hCAFE_F00D);
        check("arst_cnt1",   cnt, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
